// File: rtl/ibex_fetch_bus_arbiter.sv
// Shares the instruction-bus port between fetch and aux readers, routing responses in order.
// Optional conflict-cycle counter enabled by the IBEX_FETCH_ARB_PERF_EN macro.
module ibex_fetch_bus_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned StarveLimit    = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        f_req_i,
  input  logic [31:0] f_addr_i,
  output logic        f_gnt_o,
  output logic        f_rvalid_o,
  input  logic        a_req_i,
  input  logic [31:0] a_addr_i,
  output logic        a_gnt_o,
  output logic        a_rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic [15:0] conflict_cnt_o
);

  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned StW  = $clog2(StarveLimit + 1);
  localparam logic [PtrW-1:0] PtrMax  = PtrW'(MaxOutstanding - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);
  localparam logic [StW-1:0]  StMax   = StW'(StarveLimit);

  typedef enum logic [1:0] {LockNone, LockF, LockA} lock_state_e;

  lock_state_e lock_q, lock_d;
  logic                      sel;
  logic                      sel_req;
  logic                      bus_gnt;
  logic                      push;
  logic                      pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      head_id;
  logic [MaxOutstanding-1:0] id_q;
  logic [PtrW-1:0]           wr_ptr_q;
  logic [PtrW-1:0]           rd_ptr_q;
  logic [CntW-1:0]           cnt_q;
  logic [StW-1:0]            starve_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= LockNone;
    end else begin
      lock_q <= lock_d;
    end
  end

  // An ungranted request pins the current source until the bus accepts it.
  always_comb begin
    lock_d = lock_q;
    if (bus_req_o && !bus_gnt_i) begin
      lock_d = sel ? LockA : LockF;
    end else if (bus_req_o) begin
      lock_d = LockNone;
    end
  end

  always_comb begin
    sel = 1'b0;
    case (lock_q)
      LockF:   sel = 1'b0;
      LockA:   sel = 1'b1;
      default: begin
        if (a_req_i && (starve_q == StMax)) begin
          sel = 1'b1;
        end else if (!f_req_i && a_req_i) begin
          sel = 1'b1;
        end
      end
    endcase
  end

  assign fifo_full  = (cnt_q == CntFull);
  assign fifo_empty = (cnt_q == '0);
  assign head_id    = id_q[rd_ptr_q];

  // A full FIFO blocks the bus even when a response frees a slot this cycle.
  assign sel_req    = sel ? a_req_i : f_req_i;
  assign bus_req_o  = sel_req & ~fifo_full;
  assign bus_addr_o = bus_req_o ? (sel ? a_addr_i : f_addr_i) : 32'h0;
  assign bus_gnt    = bus_gnt_i & bus_req_o;
  assign f_gnt_o    = bus_gnt & ~sel;
  assign a_gnt_o    = bus_gnt & sel;

  assign push       = bus_gnt;
  assign pop        = bus_rvalid_i & ~fifo_empty;
  assign f_rvalid_o = pop & ~head_id;
  assign a_rvalid_o = pop & head_id;
  assign rdata_o    = bus_rdata_i;
  assign err_o      = bus_err_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        id_q[wr_ptr_q] <= sel;
        wr_ptr_q       <= (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else if (!a_req_i || a_gnt_o) begin
      starve_q <= '0;
    end else if (starve_q != StMax) begin
      starve_q <= starve_q + 1'b1;
    end
  end

`ifdef IBEX_FETCH_ARB_PERF_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= '0;
    end else if (f_req_i && a_req_i && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt_o = conflict_q;
`else
  assign conflict_cnt_o = 16'h0;
`endif

endmodule
